// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg
//
// Shared definitions for the serial parity transmitter:
//   - state_e          : FSM state encoding (IDLE, DATA, PARITY)
//   - PARITY_EVEN      : initial accumulator value for even parity
//   - PARITY_ODD_INIT  : initial accumulator value for odd parity
//   - xor_parity()     : reference XOR-reduced parity of a word, usable by
//                        models and benches that need the expected parity bit
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic PARITY_EVEN     = 1'b0;
    localparam logic PARITY_ODD_INIT = 1'b1;

    // Parity over the low 'width' bits of data, seeded with 'odd' so that
    // odd parity is simply the inverted XOR.
    function automatic logic xor_parity(input logic [31:0] data,
                                        input int unsigned width,
                                        input logic        odd);
        logic p;
        p = odd;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(width)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/serial_parity_shifter.sv
// serial_parity_shifter
//
// Loadable shift register with a data-bit counter. Presents the next data
// bit on bit_o and raises done_o while the last data bit of the frame is
// being presented.
//
// Configuration macro: SERIAL_PARITY_TX_MSB_FIRST_EN
//   defined   : shift left, bit_o is the register MSB (MSB first)
//   undefined : shift right, bit_o is the register LSB (LSB first)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset (register and counter to 0)
//   load_i  in   load data_i and restart the counter (wins over shift_i)
//   data_i  in   DATA_W-bit word to load
//   shift_i in   advance to the next data bit
//   bit_o   out  current data bit
//   done_o  out  current bit is the last data bit of the frame
module serial_parity_shifter
    import serial_parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = data_i;
            cnt_d = '0;
        end else if (shift_i) begin
`ifdef SERIAL_PARITY_TX_MSB_FIRST_EN
            sr_d = {sr_q[DATA_W-2:0], 1'b0};
`else
            sr_d = {1'b0, sr_q[DATA_W-1:1]};
`endif
            // Saturate on the last bit so the counter never wraps inside a
            // frame; the next load restarts it.
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SERIAL_PARITY_TX_MSB_FIRST_EN
    assign bit_o = sr_q[DATA_W-1];
`else
    assign bit_o = sr_q[0];
`endif

    assign done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_parity_tx.sv
// serial_parity_tx
//
// Parallel-to-serial transmitter. Accepts a DATA_W-bit word, emits it one
// bit per output handshake, then one XOR-reduced parity bit.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and data stable until ready; out_valid and
// out_bit depend only on registers, never on out_ready. in_ready follows
// out_ready in the PARITY state so a new word can be taken while the
// parity bit leaves, giving back-to-back frames with no idle bubble.
//
// Configuration macro: SERIAL_PARITY_TX_MSB_FIRST_EN (MSB-first data order;
// parity, handshake and frame length unchanged).
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset, discards any frame
//   in_valid       in   in_data is valid
//   in_ready       out  a word can be accepted this cycle
//   in_data        in   word to transmit (sampled only at acceptance)
//   out_valid      out  out_bit is valid
//   out_ready      in   downstream consumes out_bit this cycle
//   out_bit        out  current serial bit
//   out_is_parity  out  current bit is the parity bit
//   out_last       out  current bit is the last of the frame
//   dbg_state      out  FSM state (serial_parity_pkg::state_e encoding)
module serial_parity_tx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_is_parity,
    output logic              out_last,
    output logic [1:0]        dbg_state
);

    localparam logic ACC_INIT = (PARITY_ODD != 0) ? PARITY_ODD_INIT : PARITY_EVEN;

    state_e state_q;
    logic   acc_q;

    logic in_hs;
    logic out_hs;
    logic sh_bit;
    logic sh_done;

    assign out_valid = (state_q != IDLE);
    assign in_ready  = (state_q == IDLE) || ((state_q == PARITY) && out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    serial_parity_shifter #(
        .DATA_W(DATA_W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (in_hs),
        .data_i (in_data),
        .shift_i(out_hs && (state_q == DATA)),
        .bit_o  (sh_bit),
        .done_o (sh_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= ACC_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        state_q <= DATA;
                        acc_q   <= ACC_INIT;
                    end
                end
                DATA: begin
                    if (out_hs) begin
                        acc_q <= acc_q ^ sh_bit;
                        if (sh_done) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    // in_hs implies out_hs here, since in_ready == out_ready.
                    if (out_hs) begin
                        if (in_hs) begin
                            state_q <= DATA;
                            acc_q   <= ACC_INIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded from registers only; IDLE drives 0 on out_bit.
    assign out_bit       = (state_q == PARITY) ? acc_q :
                           (state_q == DATA)   ? sh_bit : 1'b0;
    assign out_is_parity = (state_q == PARITY);
    assign out_last      = (state_q == PARITY);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: one even-parity and one odd-parity instance
// share all inputs. A negedge scoreboard predicts every emitted bit from the
// accepted words; table vectors and hand-written sequences cover the
// listed corner cases.
module tb_serial_parity_tx;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic       in_ready_ev, out_valid_ev, out_bit_ev, out_is_parity_ev, out_last_ev;
    logic       in_ready_od, out_valid_od, out_bit_od, out_is_parity_od, out_last_od;
    logic [1:0] dbg_ev, dbg_od;

    int total;
    int bad;

    // Entry: {is_parity, bit for even instance, bit for odd instance}
    logic [2:0] exp_q[$];
    logic       stall_prev;
    logic       held_bit;

    serial_parity_tx #(.DATA_W(DATA_W), .PARITY_ODD(0)) dut_ev (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_ev), .in_data(in_data),
        .out_valid(out_valid_ev), .out_ready(out_ready), .out_bit(out_bit_ev),
        .out_is_parity(out_is_parity_ev), .out_last(out_last_ev), .dbg_state(dbg_ev)
    );

    serial_parity_tx #(.DATA_W(DATA_W), .PARITY_ODD(1)) dut_od (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_od), .in_data(in_data),
        .out_valid(out_valid_od), .out_ready(out_ready), .out_bit(out_bit_od),
        .out_is_parity(out_is_parity_od), .out_last(out_last_od), .dbg_state(dbg_od)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Inputs change only just after posedge, so values seen at negedge are
    // the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            logic [2:0] e;
            logic       pe;
            logic       b;
            if (stall_prev) begin
                check("hold_valid", out_valid_ev, 1'b1);
                check("hold_bit", out_bit_ev, held_bit);
            end
            check("twin_valid", out_valid_od, out_valid_ev);
            check("twin_ready", in_ready_od, in_ready_ev);
            if (out_valid_ev && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_bit_even", out_bit_ev, e[1]);
                    check("sb_bit_odd", out_bit_od, e[0]);
                    check("sb_is_parity", out_is_parity_ev, e[2]);
                    check("sb_last", out_last_ev, e[2]);
                    check("sb_last_odd", out_last_od, e[2]);
                end
            end
            if (in_valid && in_ready_ev) begin
                pe = ($countones(in_data) % 2) == 1;
                for (int i = 0; i < DATA_W; i++) begin
`ifdef SERIAL_PARITY_TX_MSB_FIRST_EN
                    b = in_data[DATA_W-1-i];
`else
                    b = in_data[i];
`endif
                    exp_q.push_back({1'b0, b, b});
                end
                exp_q.push_back({1'b1, pe, ~pe});
            end
            stall_prev = out_valid_ev && !out_ready;
            held_bit   = out_bit_ev;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, out_valid_ev, 1'b0);
        check({name, "_ready"}, in_ready_ev, 1'b1);
        check({name, "_bit"}, out_bit_ev, 1'b0);
        check({name, "_par"}, out_is_parity_ev, 1'b0);
        check({name, "_last"}, out_last_ev, 1'b0);
        check({name, "_dbg"}, dbg_ev, 2'd0);
    endtask

    // Offer one word, collect the whole frame as seen on both instances.
    task automatic run_frame(input logic [7:0] w, input bit bp,
                             output logic [8:0] got_ev, output logic [8:0] got_od,
                             output logic [8:0] got_last, output int n);
        bit acc;
        bit first;
        n = 0; acc = 0; first = 0;
        got_ev = '0; got_od = '0; got_last = '0;
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && n < 9; c++) begin
            if (bp) out_ready = ($urandom_range(0, 2) != 0) ? (c % 3 == 0) : 1'b1;
            @(negedge clk);
            if (!acc) begin
                if (in_valid && in_ready_ev) begin
                    acc = 1;
                    first = 1;
                end
            end else begin
                if (first) begin
                    check("first_bit_latency", out_valid_ev, 1'b1);
                    first = 0;
                end
                if (out_valid_ev && out_ready) begin
                    got_ev[n]   = out_bit_ev;
                    got_od[n]   = out_bit_od;
                    got_last[n] = out_last_ev;
                    if (n < 8) check("in_ready_low_data", in_ready_ev, 1'b0);
                    else       check("in_ready_parity", in_ready_ev, out_ready);
                    n++;
                end
            end
            cycle();
            if (acc) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] word;
        bit         bp;
        logic [7:0] seq_lsb;   // bit i = i-th emitted data bit, LSB-first build
        logic [7:0] seq_msb;   // same, MSB-first build
        logic       par_ev;
        logic       par_od;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [8:0] g_ev, g_od, g_last;
        logic [7:0] exp_seq;
        logic [1:0] pars_ev, pars_od;
        int n, nhs, nacc, gaps, npar, frames_sent;
        bit acc, pending;

        total = 0;
        bad = 0;
        stall_prev = 1'b0;
        held_bit = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b0, 8'h07, 8'hE0, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 1'b0, 8'h01, 8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 8'h80, 8'h01, 1'b1, 1'b0};

        // clock/reset
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) cycle();
        check_idle("reset");
        check("reset_odd_valid", out_valid_od, 1'b0);
        rst_n = 1'b1;
        cycle();

        // table-driven frames
        for (int i = 0; i < 5; i++) begin
`ifdef SERIAL_PARITY_TX_MSB_FIRST_EN
            exp_seq = vecs[i].seq_msb;
`else
            exp_seq = vecs[i].seq_lsb;
`endif
            run_frame(vecs[i].word, vecs[i].bp, g_ev, g_od, g_last, n);
            check("vec_handshakes", n, 9);
            check("vec_data_seq", g_ev[7:0], exp_seq);
            check("vec_parity_even", g_ev[8], vecs[i].par_ev);
            check("vec_parity_odd", g_od[8], vecs[i].par_od);
            check("vec_last_flags", g_last, 9'h100);
            check("vec_idle_after", out_valid_ev, 1'b0);
        end

        // back-to-back FF then 01 with in_valid held high
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        nhs = 0; nacc = 0; gaps = 0; npar = 0; pars_ev = '0; pars_od = '0;
        for (int c = 0; c < 60 && nhs < 18; c++) begin
            @(negedge clk);
            if (nacc > 0) begin
                if (out_valid_ev) begin
                    nhs++;
                    if (out_is_parity_ev && npar < 2) begin
                        pars_ev[npar] = out_bit_ev;
                        pars_od[npar] = out_bit_od;
                        npar++;
                    end
                end else begin
                    gaps++;
                end
            end
            if (in_valid && in_ready_ev) begin
                nacc++;
                if (nacc == 2) check("b2b_accept_in_parity", out_is_parity_ev, 1'b1);
            end
            cycle();
            if (nacc == 1) in_data = 8'h01;
            else if (nacc >= 2) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
            end
        end
        check("b2b_handshakes", nhs, 18);
        check("b2b_gaps", gaps, 0);
        check("b2b_accepts", nacc, 2);
        check("b2b_parity_even", pars_ev, 2'b10);
        check("b2b_parity_odd", pars_od, 2'b01);
        cycle();
        check("b2b_idle_after", out_valid_ev, 1'b0);

        // reset after 3 data bits of A5
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        nhs = 0; acc = 0;
        for (int c = 0; c < 40 && nhs < 3; c++) begin
            @(negedge clk);
            if (acc && out_valid_ev && out_ready) nhs++;
            if (!acc && in_valid && in_ready_ev) acc = 1;
            cycle();
            if (acc) in_valid = 1'b0;
        end
        check("midreset_bits_before", nhs, 3);
        check("midreset_busy", out_valid_ev, 1'b1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_idle("midreset");
        run_frame(8'h80, 1'b0, g_ev, g_od, g_last, n);
        check("post_reset_handshakes", n, 9);
        check("post_reset_parity_even", g_ev[8], 1'b1);
        check("post_reset_parity_odd", g_od[8], 1'b0);

        // randomized traffic against the scoreboard
        frames_sent = 0; pending = 0; in_valid = 1'b0;
        for (int c = 0; c < 3000 && frames_sent < 30; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                in_data = 8'($urandom);
                pending = 1;
            end
            @(negedge clk);
            if (in_valid && in_ready_ev) begin
                pending = 0;
                frames_sent++;
            end
            cycle();
            if (!pending) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
            end
        end
        check("rnd_frames", frames_sent, 30);
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || out_valid_ev); c++) cycle();
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_idle", out_valid_ev, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
